seg_scan: RTL and testbench
===========================

# seg_scan

Four-digit seven-segment scan driver that sits directly downstream of the 4×4-bit register file. It walks the read address 3→2→1→0 and fetches each nibble. It decodes each nibble to hexadecimal segment patterns and time-multiplexes them onto a common-anode display, with a blanking cycle between digits to suppress ghosting. It replaces the free-running select counter plus standalone decoder pairing, and keeps digit select and displayed data locked together by construction.

## Interface
- DIV, 50000: digit dwell period in clk cycles (prescaler terminal count + 1); legal range 4..2^20.
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- rd_addr  output  2  register-file read address (digit index being fetched or shown).
- rd_data  input  4  register-file read data; may be combinational or one-cycle registered read.
- digit_en  input  4  per-digit enable mask, bit i enables digit i; sampled in the FETCH state.
- seg  output  8  segments, active-low; seg[7]=dp (always 1), seg[6:0]=g..a.
- sel  output  4  digit anodes, active-low; sel[i]=0 lights digit i.

## Operation
- Prescaler: free-running counter 0..DIV-1, width clog2(DIV); `tick` = (count == DIV-1); wraps to 0 after DIV-1.
- Digit index idx (2 bits) drives rd_addr directly. idx decrements modulo 4: 3→2→1→0→3.
- FSM states:
  - BLANK: 1 cycle; seg=0xFF, sel=0xF. Always → FETCH.
  - FETCH: 1 cycle; seg=0xFF, sel=0xF; rd_data and digit_en[idx] are captured at the end of the cycle. Always → SHOW.
  - SHOW: seg = pattern for the captured nibble, sel = ~(1<<idx). On tick → BLANK with idx decremented; otherwise stay.
- Hex decode (seg as hex): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E.
- Masked digit (captured digit_en bit = 0): SHOW drives seg=0xFF and sel=0xF for the full dwell. The index still advances normally.
- rd_data is ignored outside FETCH. Register-file writes during SHOW take effect on that digit's next visit.

## Timing
- Reset values (cycle after rst sampled high): state=BLANK, idx=3, rd_addr=3, prescaler=0, seg=0xFF, sel=0xF, captured nibble=0, zero-blank flag=0.
- After rst deasserts: FETCH in cycle 1, SHOW of digit 3 from cycle 2. Outputs are registered.
- Per digit: 1 BLANK + 1 FETCH + (DIV-2) SHOW cycles = exactly DIV cycles. Full frame = 4·DIV cycles.
- rd_addr changes only on the SHOW→BLANK edge and stays stable for the entire BLANK/FETCH/SHOW span. A registered read is therefore valid by the end of FETCH.
- The prescaler is not restarted by FSM transitions; only rst clears it. The first dwell after reset is DIV cycles, like every other dwell.
- rst asserted mid-SHOW: the display blanks on the next edge and the scan restarts at digit 3.
- sel never has more than one bit low. seg/sel are never non-blank during BLANK or FETCH.

## Configuration
- SEG_SCAN_ZBLANK_EN defined: leading-zero suppression.
  - A flag clears when idx=3 enters BLANK.
  - The flag sets when a captured nibble is nonzero.
  - Digits 3..1 whose captured nibble is 0 while the flag is still clear show seg=0xFF. sel still lights the digit, so brightness timing is unchanged.
  - Digit 0 is never zero-blanked.
  - digit_en masking takes precedence; masked digits still update the flag from their data.
- Undefined: no suppression; zeros display as 0xC0. The flag logic is absent.

## Test plan
- Reset: hold rst 3 cycles with random inputs -> seg=0xFF, sel=0xF, rd_addr=3; SHOW of digit 3 begins exactly 2 cycles after release.
- Scan order, DIV=8, registers {3:1, 2:2, 1:3, 0:4}, digit_en=0xF -> (seg,sel) sequence (F9,7),(A4,B),(B0,D),(99,E), each held 6 cycles with 2 blank cycles between; rd_addr 3,2,1,0 repeating every 32 cycles.
- Mask: digit_en=0b1010, same data -> digits 3 and 1 show F9/B0; digits 2 and 0 slots stay seg=0xFF, sel=0xF for 8 cycles each.
- Leading zeros, data {0,0,0,5}: with SEG_SCAN_ZBLANK_EN, digits 3..1 seg=0xFF and digit 0 seg=0x92. Without the macro, the display shows C0,C0,C0,92.
- All zero, macro on -> only digit 0 shows 0xC0. Data {0,7,0,0} -> digit 3 blank, then F8, C0, C0.
- Mid-operation reset, DIV=8: assert rst during the SHOW of digit 1 -> blank next cycle. After release, rd_addr=3 and the first lit digit is digit 3.

Source files
------------

// File: rtl/seg_scan_if.sv
// Bundles the register-file read port and the display outputs of the scan driver.
// The master side is the scan driver; the slave side is the register file plus display.
interface seg_scan_if;
  logic [1:0] rd_addr;
  logic [3:0] rd_data;
  logic [3:0] digit_en;
  logic [7:0] seg;
  logic [3:0] sel;

  modport master (output rd_addr, seg, sel, input rd_data, digit_en);
  modport slave  (input rd_addr, seg, sel, output rd_data, digit_en);
endinterface

// File: rtl/seg_scan.sv
// Four-digit common-anode seven-segment scan driver (BLANK/FETCH/SHOW per digit, digits 3..0).
// Optional leading-zero suppression is built when SEG_SCAN_ZBLANK_EN is defined.
module seg_scan #(
  parameter int DIV = 50000
) (
  input  logic      clk,
  input  logic      rst,
  seg_scan_if.master bus
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  typedef enum logic [1:0] {BLANK, FETCH, SHOW} state_t;

  state_t        state_reg;
  logic [CW-1:0] count_reg;
  logic [1:0]    idx_reg;
  logic [7:0]    seg_reg;
  logic [3:0]    sel_reg;
  logic          tick;
  logic [7:0]    seg_show;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  assign tick        = (count_reg == LAST);
  assign bus.rd_addr = idx_reg;
  assign bus.seg     = seg_reg;
  assign bus.sel     = sel_reg;

`ifdef SEG_SCAN_ZBLANK_EN
  logic zflag_reg;
  logic zero_blank;
  // Digit 0 is exempt so an all-zero value still shows a single 0.
  assign zero_blank = (bus.rd_data == 4'h0) && !zflag_reg && (idx_reg != 2'd0);
  assign seg_show   = zero_blank ? 8'hFF : {1'b1, hex7(bus.rd_data)};

  always_ff @(posedge clk) begin
    if (rst) begin
      zflag_reg <= 1'b0;
    end else if (state_reg == FETCH) begin
      zflag_reg <= zflag_reg | (bus.rd_data != 4'h0);
    end else if (state_reg == SHOW && tick && idx_reg == 2'd0) begin
      zflag_reg <= 1'b0;
    end
  end
`else
  assign seg_show = {1'b1, hex7(bus.rd_data)};
`endif

  // seg/sel are computed from the next state so they are valid in the same cycle as it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= BLANK;
      count_reg <= '0;
      idx_reg   <= 2'd3;
      seg_reg   <= 8'hFF;
      sel_reg   <= 4'hF;
    end else begin
      count_reg <= tick ? '0 : count_reg + 1'b1;
      case (state_reg)
        BLANK: begin
          state_reg <= FETCH;
          seg_reg   <= 8'hFF;
          sel_reg   <= 4'hF;
        end
        FETCH: begin
          state_reg <= SHOW;
          if (bus.digit_en[idx_reg]) begin
            seg_reg <= seg_show;
            sel_reg <= ~(4'b0001 << idx_reg);
          end else begin
            seg_reg <= 8'hFF;
            sel_reg <= 4'hF;
          end
        end
        SHOW: begin
          if (tick) begin
            state_reg <= BLANK;
            idx_reg   <= idx_reg - 2'd1;
            seg_reg   <= 8'hFF;
            sel_reg   <= 4'hF;
          end
        end
        default: begin
          state_reg <= BLANK;
          seg_reg   <= 8'hFF;
          sel_reg   <= 4'hF;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seg_scan.sv
// Directed-vector bench for seg_scan with DIV=8: each vector is checked cycle by cycle over two frames.
module tb_seg_scan;
  localparam int DIV = 8;

  typedef struct {
    logic [15:0] data;    // {d3,d2,d1,d0}
    logic [3:0]  en;
    logic [31:0] seg_zb;  // expected seg {d3,d2,d1,d0} with zero suppression
    logic [31:0] seg_nz;  // expected seg without zero suppression
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] regs [4];
  logic [3:0] en_drv = 4'hF;
  int         errors = 0;
  int         checks = 0;
  vec_t       vecs [9];

  seg_scan_if bus();
  assign bus.rd_data  = regs[bus.rd_addr];
  assign bus.digit_en = en_drv;

  seg_scan #(.DIV(DIV)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string name, input int cyc, input logic [7:0] eseg,
                       input logic [3:0] esel, input logic [1:0] eaddr);
    checks++;
    if (bus.seg !== eseg || bus.sel !== esel || bus.rd_addr !== eaddr) begin
      errors++;
      $display("FAIL %s cycle %0d: got seg=%h sel=%h addr=%0d, expected seg=%h sel=%h addr=%0d",
               name, cyc, bus.seg, bus.sel, bus.rd_addr, eseg, esel, eaddr);
    end
  endtask

  task automatic load(input vec_t v);
    for (int d = 0; d < 4; d++) regs[d] = v.data[d*4 +: 4];
    en_drv = v.en;
  endtask

  // Holds rst for 3 edges, checking the blank reset outputs; returns at cycle 0 with rst low.
  task automatic do_reset(input vec_t v, input bit scramble);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (scramble) begin
        for (int d = 0; d < 4; d++) regs[d] = 4'($urandom_range(0, 15));
        en_drv = 4'($urandom_range(0, 15));
      end
      @(negedge clk);
      check("reset", i, 8'hFF, 4'hF, 2'd3);
    end
    load(v);
    rst = 1'b0;
  endtask

  // Starts at cycle 0 after reset release; checks every cycle of nframes frames.
  task automatic run_frames(input string name, input vec_t v, input int nframes);
    logic [31:0] segs;
    logic [7:0]  eseg;
    logic [3:0]  esel;
    int          d, pos;
`ifdef SEG_SCAN_ZBLANK_EN
    segs = v.seg_zb;
`else
    segs = v.seg_nz;
`endif
    for (int k = 0; k < nframes * 4 * DIV; k++) begin
      if (k > 0) @(negedge clk);
      d   = 3 - ((k / DIV) % 4);
      pos = k % DIV;
      eseg = 8'hFF;
      esel = 4'hF;
      if (pos >= 2 && v.en[d]) begin
        eseg = segs[d*8 +: 8];
        esel = ~(4'b0001 << d);
      end
      check(name, k, eseg, esel, 2'(d));
    end
  endtask

  initial begin
    vecs[0] = '{16'h1234, 4'hF, 32'hF9A4B099, 32'hF9A4B099};
    vecs[1] = '{16'h1234, 4'hA, 32'hF9FFB0FF, 32'hF9FFB0FF};
    vecs[2] = '{16'h0005, 4'hF, 32'hFFFFFF92, 32'hC0C0C092};
    vecs[3] = '{16'h0000, 4'hF, 32'hFFFFFFC0, 32'hC0C0C0C0};
    vecs[4] = '{16'h0700, 4'hF, 32'hFFF8C0C0, 32'hC0F8C0C0};
    vecs[5] = '{16'hABCD, 4'hF, 32'h8883C6A1, 32'h8883C6A1};
    vecs[6] = '{16'hEF89, 4'hF, 32'h868E8090, 32'h868E8090};
    vecs[7] = '{16'h5000, 4'h7, 32'hFFC0C0C0, 32'hFFC0C0C0};
    vecs[8] = '{16'h0601, 4'hF, 32'hFF82C0F9, 32'hC082C0F9};

    load(vecs[0]);
    @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      do_reset(vecs[i], i == 0);
      run_frames($sformatf("vec%0d", i), vecs[i], 2);
      @(negedge clk);
    end

    // Mid-SHOW reset of digit 1: display blanks on the next edge, scan restarts at digit 3.
    do_reset(vecs[0], 1'b0);
    repeat (2 * DIV + 4) @(negedge clk);
    check("mid_show_d1", 2 * DIV + 4, 8'hB0, 4'hD, 2'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_blank", 0, 8'hFF, 4'hF, 2'd3);
    do_reset(vecs[0], 1'b0);
    run_frames("after_mid_rst", vecs[0], 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
